mmu_cache_top: RTL and testbench



---
 rtl/mmu_pkg.sv | 28 ++
 rtl/cache_and_ram.sv | 79 +++++++
 rtl/mmu_cache_top_stat_counters.sv | 33 +++
 rtl/tlb.sv | 70 +++++++
 rtl/mmu_cache_top.sv | 235 +++++++++++++++++++++++
 tb/tb_mmu_cache_top.sv | 316 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the MMU/cache top level.
//   mmu_state_e   - request FSM states
//   PERM_*        - bit positions inside a {X,W,R} permission field
//   MODE_*        - request mode encoding (read / write)
//   perm_ok()     - does a permission field allow the given mode
package mmu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WALK_REQ,
        WALK_WAIT,
        ACCESS,
        RESP
    } mmu_state_e;

    localparam int unsigned PERM_R = 0;
    localparam int unsigned PERM_W = 1;
    localparam int unsigned PERM_X = 2;

    localparam logic MODE_RD = 1'b0;
    localparam logic MODE_WR = 1'b1;

    function automatic logic perm_ok(input logic [2:0] perm, input logic mode);
        return (mode == MODE_WR) ? perm[PERM_W] : perm[PERM_R];
    endfunction

endpackage

// File: rtl/cache_and_ram.sv
// cache_and_ram: direct-mapped write-through, write-allocate cache over a
// word-addressed RAM.
//   clk, rst   - clock, synchronous active-high reset (invalidates lines)
//   in_valid   - request, held stable until out_valid
//   mode       - 1 = write, 0 = read
//   addr, wdata- word address and write data
//   out_valid  - one-cycle completion pulse
//   out        - read data, valid with out_valid on reads
module cache_and_ram #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;
    localparam logic [1:0]  MISS_WAIT = 2'd2;

    logic [DATA_WIDTH-1:0]  ram       [1 << ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]  line_data [LINES];
    logic [TAG_WIDTH-1:0]   line_tag  [LINES];
    logic [LINES-1:0]       line_valid;
    logic [1:0]             wait_cnt;
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   line_hit;
    logic                   do_op;

    assign idx      = addr[INDEX_WIDTH-1:0];
    assign tag      = addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign line_hit = line_valid[idx] && (line_tag[idx] == tag);
    // The cycle out_valid is high the request is still asserted; it must not
    // start a second operation.
    assign do_op    = in_valid && !out_valid && (line_hit || wait_cnt == MISS_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            wait_cnt   <= '0;
            line_valid <= '0;
            out        <= '0;
        end else begin
            out_valid <= do_op;
            if (do_op) begin
                wait_cnt        <= '0;
                line_valid[idx] <= 1'b1;
                if (!mode) begin
                    out <= line_hit ? line_data[idx] : ram[addr];
                end
            end else if (in_valid && !out_valid) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_op) begin
            line_tag[idx] <= tag;
            if (mode) begin
                ram[addr]      <= wdata;
                line_data[idx] <= wdata;
            end else if (!line_hit) begin
                line_data[idx] <= ram[addr];
            end
        end
    end

endmodule

// File: rtl/mmu_cache_top_stat_counters.sv
// mmu_stat_counters: three saturating event counters.
//   clk, rst                       - clock, synchronous active-high reset
//   inc_hit, inc_miss, inc_fault   - one-cycle increment strobes
//   stat_hit, stat_miss, stat_fault- counts, stick at all-ones
module mmu_stat_counters #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_hit,
    input  logic                 inc_miss,
    input  logic                 inc_fault,
    output logic [CNT_WIDTH-1:0] stat_hit,
    output logic [CNT_WIDTH-1:0] stat_miss,
    output logic [CNT_WIDTH-1:0] stat_fault
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit   <= '0;
            stat_miss  <= '0;
            stat_fault <= '0;
        end else begin
            if (inc_hit && stat_hit != '1)
                stat_hit <= stat_hit + 1'b1;
            if (inc_miss && stat_miss != '1)
                stat_miss <= stat_miss + 1'b1;
            if (inc_fault && stat_fault != '1)
                stat_fault <= stat_fault + 1'b1;
        end
    end

endmodule

// File: rtl/tlb.sv
// tlb: fully associative translation buffer with round-robin replacement.
//   clk, rst        - clock, synchronous active-high reset (invalidates all)
//   flush           - invalidate all entries; wins over a same-cycle write
//   lookup_vpn      - combinational lookup key
//   hit, hit_ppn, hit_perm - lookup result
//   wr_en, wr_vpn, wr_ppn, wr_perm - install one entry
module tlb #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned VPN_WIDTH = 20,
    parameter int unsigned PPN_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [VPN_WIDTH-1:0] lookup_vpn,
    output logic                 hit,
    output logic [PPN_WIDTH-1:0] hit_ppn,
    output logic [2:0]           hit_perm,
    input  logic                 wr_en,
    input  logic [VPN_WIDTH-1:0] wr_vpn,
    input  logic [PPN_WIDTH-1:0] wr_ppn,
    input  logic [2:0]           wr_perm
);

    localparam int unsigned PTR_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0]   valid;
    logic [VPN_WIDTH-1:0] vpn_tab  [ENTRIES];
    logic [PPN_WIDTH-1:0] ppn_tab  [ENTRIES];
    logic [2:0]           perm_tab [ENTRIES];
    logic [PTR_WIDTH-1:0] victim;

    always_comb begin
        hit      = 1'b0;
        hit_ppn  = '0;
        hit_perm = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && vpn_tab[i] == lookup_vpn) begin
                hit      = 1'b1;
                hit_ppn  = ppn_tab[i];
                hit_perm = perm_tab[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[victim] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            victim <= '0;
        end else if (wr_en && !flush) begin
            victim <= (victim == PTR_WIDTH'(ENTRIES - 1)) ? '0 : victim + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            vpn_tab[victim]  <= wr_vpn;
            ppn_tab[victim]  <= wr_ppn;
            perm_tab[victim] <= wr_perm;
        end
    end

endmodule

// File: rtl/mmu_cache_top.sv
// mmu_cache_top: CPU load/store front end. Translates through the TLB,
// refills it from a page-table walker on miss, checks R/W permission and
// accesses cache_and_ram. One request outstanding at a time.
//   clk, rst                      - clock, synchronous active-high reset
//   req_*                         - CPU request (valid/ready), mmu_en bypass
//   resp_valid/data/fault         - one-cycle response
//   ptw_req_* / ptw_resp_*        - walker request handshake and result
//   tlb_flush                     - invalidate the TLB (any state)
//   stat_hit/miss/fault           - saturating statistics
module mmu_cache_top
    import mmu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned VPN_WIDTH   = 20,
    parameter int unsigned PPN_WIDTH   = 20,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [31:0]           req_vaddr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  mmu_en,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault,
    output logic                  ptw_req_valid,
    input  logic                  ptw_req_ready,
    output logic [VPN_WIDTH-1:0]  ptw_req_vpn,
    input  logic                  ptw_resp_valid,
    input  logic [PPN_WIDTH-1:0]  ptw_resp_ppn,
    input  logic [2:0]            ptw_resp_perm,
    input  logic                  ptw_resp_fault,
    input  logic                  tlb_flush,
    output logic [CNT_WIDTH-1:0]  stat_hit,
    output logic [CNT_WIDTH-1:0]  stat_miss,
    output logic [CNT_WIDTH-1:0]  stat_fault
);

    localparam int unsigned OFF_WIDTH = 32 - VPN_WIDTH;
    localparam int unsigned PA_WIDTH  = PPN_WIDTH + OFF_WIDTH;

    mmu_state_e state, next_state;

    logic                  mode_q;
    logic [31:0]           vaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  en_q;
    logic                  fault_q;
    logic                  drop_q;
    logic [ADDR_WIDTH-1:0] paddr_q;

    logic                  tlb_hit;
    logic [PPN_WIDTH-1:0]  tlb_hit_ppn;
    logic [2:0]            tlb_hit_perm;
    logic                  tlb_wr_en;
    logic                  cache_in_valid;
    logic                  cache_out_valid;
    logic [DATA_WIDTH-1:0] cache_out;
    logic                  inc_hit, inc_miss, inc_fault;
    logic                  perm_pass;
    logic [VPN_WIDTH-1:0]  vpn_q;
    logic [PA_WIDTH-1:0]   hit_pa;
    logic                  unused_bits;

    assign vpn_q       = vaddr_q[31 -: VPN_WIDTH];
    assign hit_pa      = {tlb_hit_ppn, vaddr_q[OFF_WIDTH-1:0]};
    assign perm_pass   = perm_ok(tlb_hit_perm, mode_q);
    assign ptw_req_vpn = vpn_q;
    assign resp_data   = rdata_q;
    assign unused_bits = ^{hit_pa[PA_WIDTH-1:ADDR_WIDTH], tlb_hit_perm[PERM_X]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_fault     = 1'b0;
        ptw_req_valid  = 1'b0;
        cache_in_valid = 1'b0;
        tlb_wr_en      = 1'b0;
        inc_hit        = 1'b0;
        inc_miss       = 1'b0;
        inc_fault      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (!en_q) begin
                    next_state = ACCESS;
                end else if (tlb_hit) begin
                    inc_hit    = 1'b1;
                    next_state = perm_pass ? ACCESS : RESP;
                end else begin
                    inc_miss   = 1'b1;
                    next_state = WALK_REQ;
                end
            end
            WALK_REQ: begin
                ptw_req_valid = 1'b1;
                if (ptw_req_ready) next_state = WALK_WAIT;
            end
            WALK_WAIT: begin
                if (ptw_resp_valid) begin
                    if (drop_q) begin
                        next_state = LOOKUP;
                    end else if (ptw_resp_fault) begin
                        next_state = RESP;
                    end else begin
                        tlb_wr_en  = 1'b1;
                        next_state = LOOKUP;
                    end
                end
            end
            ACCESS: begin
                cache_in_valid = 1'b1;
                if (cache_out_valid) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                inc_fault  = fault_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_RD;
            vaddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
            paddr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mode_q  <= req_mode;
                        vaddr_q <= req_vaddr;
                        wdata_q <= req_wdata;
                        en_q    <= mmu_en;
                        fault_q <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                LOOKUP: begin
                    if (!en_q) begin
                        paddr_q <= vaddr_q[ADDR_WIDTH-1:0];
                    end else if (tlb_hit) begin
                        paddr_q <= hit_pa[ADDR_WIDTH-1:0];
                        if (!perm_pass) fault_q <= 1'b1;
                    end
                end
                WALK_WAIT: begin
                    // A flush while the walk is in flight makes the pending
                    // result stale; it is consumed but ignored.
                    if (ptw_resp_valid) begin
                        if (!drop_q && ptw_resp_fault) fault_q <= 1'b1;
                        drop_q <= 1'b0;
                    end else if (tlb_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cache_out_valid && mode_q == MODE_RD) rdata_q <= cache_out;
                end
                default: ;
            endcase
        end
    end

    tlb #(
        .ENTRIES   (TLB_ENTRIES),
        .VPN_WIDTH (VPN_WIDTH),
        .PPN_WIDTH (PPN_WIDTH)
    ) u_tlb (
        .clk        (clk),
        .rst        (rst),
        .flush      (tlb_flush),
        .lookup_vpn (vpn_q),
        .hit        (tlb_hit),
        .hit_ppn    (tlb_hit_ppn),
        .hit_perm   (tlb_hit_perm),
        .wr_en      (tlb_wr_en),
        .wr_vpn     (vpn_q),
        .wr_ppn     (ptw_resp_ppn),
        .wr_perm    (ptw_resp_perm)
    );

    cache_and_ram #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_cache (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cache_in_valid),
        .mode      (mode_q),
        .addr      (paddr_q),
        .wdata     (wdata_q),
        .out_valid (cache_out_valid),
        .out       (cache_out)
    );

    mmu_stat_counters #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .inc_hit    (inc_hit),
        .inc_miss   (inc_miss),
        .inc_fault  (inc_fault),
        .stat_hit   (stat_hit),
        .stat_miss  (stat_miss),
        .stat_fault (stat_fault)
    );

endmodule

// File: tb/tb_mmu_cache_top.sv
// tb_mmu_cache_top: directed scenarios followed by random requests, checked
// against a page-table / TLB-contents / memory reference model. A second
// instance with 2-bit counters shares all inputs to exercise saturation.
module tb_mmu_cache_top;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_mode, mmu_en;
    logic [31:0]   req_vaddr;
    logic [DW-1:0] req_wdata;
    logic          ptw_req_ready, ptw_resp_valid, ptw_resp_fault, tlb_flush;
    logic [19:0]   ptw_resp_ppn;
    logic [2:0]    ptw_resp_perm;

    logic          req_ready, resp_valid, resp_fault, ptw_req_valid;
    logic [DW-1:0] resp_data;
    logic [19:0]   ptw_req_vpn;
    logic [31:0]   stat_hit, stat_miss, stat_fault;

    logic          req_ready_2, resp_valid_2, resp_fault_2, ptw_req_valid_2;
    logic [DW-1:0] resp_data_2;
    logic [19:0]   ptw_req_vpn_2;
    logic [1:0]    stat_hit_2, stat_miss_2, stat_fault_2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    mmu_cache_top #(.ADDR_WIDTH(AW), .INDEX_WIDTH(6), .DATA_WIDTH(DW), .TLB_ENTRIES(16),
                    .VPN_WIDTH(20), .PPN_WIDTH(20), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_vaddr(req_vaddr), .req_wdata(req_wdata), .mmu_en(mmu_en),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
        .ptw_resp_perm(ptw_resp_perm), .ptw_resp_fault(ptw_resp_fault), .tlb_flush(tlb_flush),
        .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_fault(stat_fault));

    mmu_cache_top #(.ADDR_WIDTH(AW), .INDEX_WIDTH(6), .DATA_WIDTH(DW), .TLB_ENTRIES(16),
                    .VPN_WIDTH(20), .PPN_WIDTH(20), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_2),
        .req_mode(req_mode), .req_vaddr(req_vaddr), .req_wdata(req_wdata), .mmu_en(mmu_en),
        .resp_valid(resp_valid_2), .resp_data(resp_data_2), .resp_fault(resp_fault_2),
        .ptw_req_valid(ptw_req_valid_2), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn_2),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
        .ptw_resp_perm(ptw_resp_perm), .ptw_resp_fault(ptw_resp_fault), .tlb_flush(tlb_flush),
        .stat_hit(stat_hit_2), .stat_miss(stat_miss_2), .stat_fault(stat_fault_2));

    // ---------------- reference model ----------------
    logic [19:0] pt_ppn   [bit [19:0]];
    logic [2:0]  pt_perm  [bit [19:0]];
    bit          pt_fault [bit [19:0]];
    logic [19:0] tlb_ppn_m  [bit [19:0]];
    logic [2:0]  tlb_perm_m [bit [19:0]];
    logic [31:0] mem_m [bit [15:0]];
    logic [19:0] vpn_list [8];
    longint      exp_hit = 0, exp_miss = 0, exp_fault = 0;

    // walker bookkeeping
    int unsigned walk_count = 0;
    logic [19:0] last_walk_vpn = '0;
    bit          walker_waiting = 1'b0;
    bit          walker_hold = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_stats();
        check("stat_hit",     64'(stat_hit),     64'(sat(exp_hit, 32)));
        check("stat_miss",    64'(stat_miss),    64'(sat(exp_miss, 32)));
        check("stat_fault",   64'(stat_fault),   64'(sat(exp_fault, 32)));
        check("stat_hit_2b",  64'(stat_hit_2),   64'(sat(exp_hit, 2)));
        check("stat_miss_2b", 64'(stat_miss_2),  64'(sat(exp_miss, 2)));
        check("stat_fault_2b",64'(stat_fault_2), 64'(sat(exp_fault, 2)));
    endtask

    task automatic model_reset();
        exp_hit = 0; exp_miss = 0; exp_fault = 0;
        tlb_ppn_m.delete(); tlb_perm_m.delete();
    endtask

    // Walker: accepts requests after a random delay and answers from the page table.
    initial begin : walker
        logic [19:0] wvpn;
        logic [19:0] pend_vpn;
        bit          pend;
        pend = 1'b0; pend_vpn = '0;
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0;
        ptw_resp_ppn = '0; ptw_resp_perm = '0; ptw_resp_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && !rst)
                check("ptw_req_hold", {43'd0, ptw_req_valid, ptw_req_vpn}, {43'd0, 1'b1, pend_vpn});
            pend = 1'b0;
            if (ptw_req_valid && !rst) begin
                if (!walker_hold && $urandom_range(0, 2) != 0) begin
                    wvpn = ptw_req_vpn;
                    ptw_req_ready = 1'b1;
                    walk_count++;
                    last_walk_vpn = wvpn;
                    @(negedge clk);
                    ptw_req_ready = 1'b0;
                    walker_waiting = 1'b1;
                    repeat ($urandom_range(3, 5)) @(negedge clk);
                    ptw_resp_valid = 1'b1;
                    if (pt_fault.exists(wvpn) && !pt_fault[wvpn]) begin
                        ptw_resp_fault = 1'b0;
                        ptw_resp_ppn   = pt_ppn[wvpn];
                        ptw_resp_perm  = pt_perm[wvpn];
                    end else begin
                        ptw_resp_fault = 1'b1;
                        ptw_resp_ppn   = 20'($urandom);
                        ptw_resp_perm  = 3'b111;
                    end
                    @(negedge clk);
                    ptw_resp_valid = 1'b0;
                    walker_waiting = 1'b0;
                    ptw_resp_ppn   = 20'($urandom);
                    ptw_resp_perm  = 3'($urandom);
                    ptw_resp_fault = 1'($urandom);
                end else begin
                    pend = 1'b1;
                    pend_vpn = ptw_req_vpn;
                end
            end
        end
    end

    task automatic flush_tlb();
        tlb_flush = 1'b1;
        @(negedge clk);
        tlb_flush = 1'b0;
        tlb_ppn_m.delete(); tlb_perm_m.delete();
    endtask

    // One request; called right after a negedge with the DUT idle.
    task automatic do_req(input bit mode, input logic [31:0] va, input logic [31:0] wd,
                          input bit en, input bit flush_walk, input int exp_lat);
        logic [19:0] vpn;
        logic [15:0] pa;
        logic [31:0] exp_data;
        bit          exp_f, known, ok;
        int unsigned walks_exp, walks0, lat;
        bit          flush_done;
        vpn = va[31:12];
        exp_f = 1'b0; exp_data = '0; known = 1'b1; walks_exp = 0; pa = va[15:0];
        if (en) begin
            if (!tlb_ppn_m.exists(vpn)) begin
                exp_miss++; walks_exp = 1;
                if (flush_walk) begin
                    tlb_ppn_m.delete(); tlb_perm_m.delete();
                    exp_miss++; walks_exp = 2;
                end
                if (pt_fault[vpn]) exp_f = 1'b1;
                else begin
                    tlb_ppn_m[vpn] = pt_ppn[vpn];
                    tlb_perm_m[vpn] = pt_perm[vpn];
                    exp_hit++;
                end
            end else begin
                exp_hit++;
            end
            if (!exp_f) begin
                ok = mode ? tlb_perm_m[vpn][1] : tlb_perm_m[vpn][0];
                if (!ok) exp_f = 1'b1;
                pa = {tlb_ppn_m[vpn][3:0], va[11:0]};
            end
        end
        if (exp_f) exp_fault++;
        else if (mode) mem_m[pa] = wd;
        else if (mem_m.exists(pa)) exp_data = mem_m[pa];
        else known = 1'b0;

        walks0 = walk_count;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_mode = mode; req_vaddr = va; req_wdata = wd; mmu_en = en;
        @(negedge clk);
        req_valid = 1'b0; req_vaddr = $urandom; req_wdata = $urandom;
        req_mode = 1'($urandom); mmu_en = 1'($urandom);
        lat = 1; flush_done = 1'b0;
        while (!resp_valid && lat < 300) begin
            if (flush_walk && !flush_done && walker_waiting) begin
                tlb_flush = 1'b1;
                flush_done = 1'b1;
            end
            @(negedge clk);
            tlb_flush = 1'b0;
            lat++;
        end
        check("resp_valid_seen", 64'(resp_valid), 64'd1);
        check("resp_fault", 64'(resp_fault), 64'(exp_f));
        if (known) check("resp_data", 64'(resp_data), 64'(exp_data));
        check("walk_count", 64'(walk_count - walks0), 64'(walks_exp));
        if (walks_exp > 0) check("ptw_req_vpn", 64'(last_walk_vpn), 64'(vpn));
        if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check("resp_one_cycle", {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
        check_stats();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(req_ready), 64'd1);
        check({tag, "_outs"},   {61'd0, resp_valid, resp_fault, ptw_req_valid}, 64'd0);
        check({tag, "_rdata"},  64'(resp_data), 64'd0);
        check_stats();
    endtask

    initial begin : main
        logic [31:0] r, va;
        logic [19:0] vpn;
        bit          en, mode, fw;
        int unsigned n;
        rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_vaddr = '0; req_wdata = '0;
        mmu_en = 1'b0; tlb_flush = 1'b0;

        vpn_list[0] = 20'h00012; vpn_list[1] = 20'h00020; vpn_list[2] = 20'h00030;
        for (int i = 3; i < 8; i++) vpn_list[i] = 20'h00100 + 20'(i * 20'h137);
        pt_ppn[20'h00012] = 20'h00003; pt_perm[20'h00012] = 3'b011; pt_fault[20'h00012] = 1'b0;
        pt_ppn[20'h00020] = 20'h00005; pt_perm[20'h00020] = 3'b001; pt_fault[20'h00020] = 1'b0;
        pt_ppn[20'h00030] = 20'h00007; pt_perm[20'h00030] = 3'b011; pt_fault[20'h00030] = 1'b1;
        for (int i = 3; i < 8; i++) begin
            r = $urandom;
            pt_ppn[vpn_list[i]]   = r[19:0];
            pt_perm[vpn_list[i]]  = (i == 7) ? 3'b100 : r[22:20];
            pt_fault[vpn_list[i]] = (i == 6);
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // bypass write then read
        do_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        do_req(1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 0);
        // miss, refill, hit (seed physical 0x3040 through bypass first)
        do_req(1'b1, 32'h0000_3040, 32'h1234_5678, 1'b0, 1'b0, 0);
        do_req(1'b0, 32'h0001_2040, 32'h0, 1'b1, 1'b0, 0);
        do_req(1'b0, 32'h0001_2040, 32'h0, 1'b1, 1'b0, 0);
        // permission fault on a read-only page
        do_req(1'b1, 32'h0000_5010, 32'hAAAA_5555, 1'b0, 1'b0, 0);
        do_req(1'b0, 32'h0002_0010, 32'h0, 1'b1, 1'b0, 0);
        do_req(1'b1, 32'h0002_0010, 32'h0BAD_0BAD, 1'b1, 1'b0, 2);
        do_req(1'b0, 32'h0002_0010, 32'h0, 1'b1, 1'b0, 0);
        // walker fault, twice
        do_req(1'b0, 32'h0003_0000, 32'h0, 1'b1, 1'b0, 0);
        do_req(1'b0, 32'h0003_0000, 32'h0, 1'b1, 1'b0, 0);
        // flush during walk
        flush_tlb();
        do_req(1'b0, 32'h0001_2040, 32'h0, 1'b1, 1'b1, 0);

        // reset while the walk request is pending
        flush_tlb();
        walker_hold = 1'b1;
        req_valid = 1'b1; req_mode = 1'b0; req_vaddr = 32'h0001_2040; mmu_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!ptw_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("walk_req_pending", 64'(ptw_req_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        walker_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_reset", {62'd0, resp_valid, ptw_req_valid}, 64'd0);
        end
        // four hits saturate the 2-bit counter
        for (int i = 0; i < 4; i++) do_req(1'b0, 32'h0001_2040, 32'h0, 1'b1, 1'b0, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            if (r[3:0] == 4'd0) flush_tlb();
            en   = (r[5:4] != 2'd0);
            mode = r[6];
            vpn  = vpn_list[r[9:7]];
            if (en) va = {vpn, 12'(r[12:10] * 4)};
            else    va = {r[31:16], pt_ppn[vpn_list[r[15:13]]][3:0], 12'(r[12:10] * 4)};
            fw = en && !tlb_ppn_m.exists(vpn) && (r[27:26] == 2'd0);
            do_req(mode, va, $urandom, en, fw, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
